// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve path: comparator kinds and FSM states.
package branch_pkg;

  typedef enum logic [2:0] {
    KIND_NONE = 3'b000,
    KIND_BEQ  = 3'b001,
    KIND_BNE  = 3'b010,
    KIND_BGE  = 3'b011,
    KIND_BLT  = 3'b100
  } sb_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EVAL     = 2'b01,
    ST_REDIRECT = 2'b10
  } brs_state_e;

  function automatic logic is_branch_kind(input logic [2:0] kind);
    return (kind == KIND_BEQ) || (kind == KIND_BNE) ||
           (kind == KIND_BGE) || (kind == KIND_BLT);
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Branch target (pc + imm) and fall-through (pc + 4) adders, combinational,
// both wrapping mod 2^32.
module branch_target_adder (
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  output logic [31:0] target,
  output logic [31:0] seq_pc
);

  assign target = pc + imm;
  assign seq_pc = pc + 32'd4;

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves one branch per two cycles using an external comparator; result at N+2.
// Mispredicts redirect fetch and hold redir_valid/redir_pc until redir_ready.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_pc,
  input  logic [31:0]      req_imm,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [2:0]       req_kind,
  input  logic             req_pred_taken,
  output logic [31:0]      cmp_operand1,
  output logic [31:0]      cmp_operand2,
  output logic [2:0]       cmp_sb_kind,
  input  logic             cmp_should_branch,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [31:0]      redir_pc,
  output logic             flush,
  output logic             resolved_valid,
  output logic             resolved_taken,
  output logic             misalign,
  output logic [CNT_W-1:0] mispredict_cnt
);

  brs_state_e       state_q, state_d;
  logic [31:0]      pc_q, pc_d, imm_q, imm_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]       kind_q, kind_d;
  logic             pred_q, pred_d;
  logic             redir_valid_q, redir_valid_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic             flush_q, flush_d;
  logic             resolved_valid_q, resolved_valid_d;
  logic             resolved_taken_q, resolved_taken_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0]      target, seq_pc;
  logic             taken;

  branch_target_adder u_adder (
    .pc     (pc_q),
    .imm    (imm_q),
    .target (target),
    .seq_pc (seq_pc)
  );

  // The comparator result is only trusted for real branch kinds.
  assign taken = is_branch_kind(kind_q) & cmp_should_branch;

  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    imm_d            = imm_q;
    rs1_d            = rs1_q;
    rs2_d            = rs2_q;
    kind_d           = kind_q;
    pred_d           = pred_q;
    redir_valid_d    = redir_valid_q;
    redir_pc_d       = redir_pc_q;
    cnt_d            = cnt_q;
    flush_d          = 1'b0;
    resolved_valid_d = 1'b0;
    resolved_taken_d = 1'b0;
    misalign_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          pc_d    = req_pc;
          imm_d   = req_imm;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          kind_d  = req_kind;
          pred_d  = req_pred_taken;
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        resolved_valid_d = 1'b1;
        resolved_taken_d = taken;
        if (taken && (target[1:0] != 2'b00)) begin
          misalign_d = 1'b1;
          state_d    = ST_IDLE;
        end else if (taken != pred_q) begin
          redir_valid_d = 1'b1;
          redir_pc_d    = taken ? target : seq_pc;
          flush_d       = 1'b1;
          state_d       = ST_REDIRECT;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (redir_ready) begin
          redir_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      pc_q             <= '0;
      imm_q            <= '0;
      rs1_q            <= '0;
      rs2_q            <= '0;
      kind_q           <= '0;
      pred_q           <= 1'b0;
      redir_valid_q    <= 1'b0;
      redir_pc_q       <= '0;
      flush_q          <= 1'b0;
      resolved_valid_q <= 1'b0;
      resolved_taken_q <= 1'b0;
      misalign_q       <= 1'b0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      imm_q            <= imm_d;
      rs1_q            <= rs1_d;
      rs2_q            <= rs2_d;
      kind_q           <= kind_d;
      pred_q           <= pred_d;
      redir_valid_q    <= redir_valid_d;
      redir_pc_q       <= redir_pc_d;
      flush_q          <= flush_d;
      resolved_valid_q <= resolved_valid_d;
      resolved_taken_q <= resolved_taken_d;
      misalign_q       <= misalign_d;
      cnt_q            <= cnt_d;
    end
  end

  assign req_ready      = (state_q == ST_IDLE);
  assign cmp_operand1   = rs1_q;
  assign cmp_operand2   = rs2_q;
  assign cmp_sb_kind    = kind_q;
  assign redir_valid    = redir_valid_q;
  assign redir_pc       = redir_pc_q;
  assign flush          = flush_q;
  assign resolved_valid = resolved_valid_q;
  assign resolved_taken = resolved_taken_q;
  assign misalign       = misalign_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed table, randomized traffic against a
// reference model, reset during redirect, and counter saturation.
module tb_branch_resolve_unit;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_pc = '0, req_imm = '0, req_rs1 = '0, req_rs2 = '0;
  logic [2:0]    req_kind = '0;
  logic          req_pred_taken = 1'b0;
  logic [31:0]   cmp_operand1, cmp_operand2;
  logic [2:0]    cmp_sb_kind;
  logic          cmp_should_branch;
  logic          redir_valid;
  logic          redir_ready = 1'b0;
  logic [31:0]   redir_pc;
  logic          flush, resolved_valid, resolved_taken, misalign;
  logic [CW-1:0] mispredict_cnt;

  int n_vec = 0;
  int n_err = 0;
  int model_cnt = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.CNT_W(CW)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_pc            (req_pc),
    .req_imm           (req_imm),
    .req_rs1           (req_rs1),
    .req_rs2           (req_rs2),
    .req_kind          (req_kind),
    .req_pred_taken    (req_pred_taken),
    .cmp_operand1      (cmp_operand1),
    .cmp_operand2      (cmp_operand2),
    .cmp_sb_kind       (cmp_sb_kind),
    .cmp_should_branch (cmp_should_branch),
    .redir_valid       (redir_valid),
    .redir_ready       (redir_ready),
    .redir_pc          (redir_pc),
    .flush             (flush),
    .resolved_valid    (resolved_valid),
    .resolved_taken    (resolved_taken),
    .misalign          (misalign),
    .mispredict_cnt    (mispredict_cnt)
  );

  // External comparator; answers 1 for non-branch kinds to prove the DUT ignores it.
  always_comb begin
    case (cmp_sb_kind)
      3'b001:  cmp_should_branch = (cmp_operand1 == cmp_operand2);
      3'b010:  cmp_should_branch = (cmp_operand1 != cmp_operand2);
      3'b011:  cmp_should_branch = ($signed(cmp_operand1) >= $signed(cmp_operand2));
      3'b100:  cmp_should_branch = ($signed(cmp_operand1) <  $signed(cmp_operand2));
      default: cmp_should_branch = 1'b1;
    endcase
  end

  typedef struct {
    logic [31:0] pc, imm, rs1, rs2;
    logic [2:0]  kind;
    logic        pred;
    int          delay;
    logic        e_taken, e_redir, e_mis;
    logic [31:0] e_pc;
    logic [CW-1:0] e_cnt;
  } vec_t;

  task automatic chk1(input string name, input logic act, input logic exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: the architectural outcome of one branch, from plain arithmetic.
  function automatic vec_t model(input logic [31:0] pc, imm, rs1, rs2,
                                 input logic [2:0] kind, input logic pred, input int delay);
    vec_t v;
    longint a, b;
    logic [31:0] tgt;
    a = longint'($signed(rs1));
    b = longint'($signed(rs2));
    v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.kind = kind; v.pred = pred; v.delay = delay;
    case (kind)
      3'd1:    v.e_taken = (rs1 == rs2);
      3'd2:    v.e_taken = (rs1 != rs2);
      3'd3:    v.e_taken = (a >= b);
      3'd4:    v.e_taken = (a < b);
      default: v.e_taken = 1'b0;
    endcase
    tgt = 32'((64'(pc) + 64'(imm)) % 64'h1_0000_0000);
    v.e_mis   = v.e_taken && (tgt % 4 != 0);
    v.e_redir = !v.e_mis && (v.e_taken != pred);
    v.e_pc    = v.e_taken ? tgt : 32'((64'(pc) + 64'd4) % 64'h1_0000_0000);
    if (v.e_redir && model_cnt < (1 << CW) - 1) model_cnt++;
    v.e_cnt = CW'(model_cnt);
    return v;
  endfunction

  task automatic run(input vec_t v);
    n_vec++;
    @(negedge clk);
    chk1("idle_req_ready", req_ready, 1'b1);
    chk1("idle_resolved_valid", resolved_valid, 1'b0);
    chk1("idle_redir_valid", redir_valid, 1'b0);
    chk1("idle_flush", flush, 1'b0);
    chk1("idle_misalign", misalign, 1'b0);
    req_valid = 1'b1; req_pc = v.pc; req_imm = v.imm; req_rs1 = v.rs1;
    req_rs2 = v.rs2; req_kind = v.kind; req_pred_taken = v.pred;
    redir_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk1("eval_req_ready", req_ready, 1'b0);
    chk1("eval_resolved_valid", resolved_valid, 1'b0);
    chk32("eval_cmp_operand1", cmp_operand1, v.rs1);
    chk32("eval_cmp_operand2", cmp_operand2, v.rs2);
    chk32("eval_cmp_sb_kind", 32'(cmp_sb_kind), 32'(v.kind));
    // Back-to-back attempt that must be held off.
    req_pc = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
    req_kind = 3'($urandom_range(0, 7)); req_pred_taken = 1'($urandom_range(0, 1));
    @(negedge clk);
    req_valid = 1'b0;
    chk1("res_resolved_valid", resolved_valid, 1'b1);
    chk1("res_resolved_taken", resolved_taken, v.e_taken);
    chk1("res_misalign", misalign, v.e_mis);
    chk1("res_redir_valid", redir_valid, v.e_redir);
    chk1("res_flush", flush, v.e_redir);
    chk1("res_req_ready", req_ready, !v.e_redir);
    chk32("res_mispredict_cnt", 32'(mispredict_cnt), 32'(v.e_cnt));
    chk32("res_cmp_operand1_held", cmp_operand1, v.rs1);
    if (v.e_redir) begin
      for (int k = 0; k <= v.delay; k++) begin
        if (k > 0) @(negedge clk);
        chk1("redir_valid_hold", redir_valid, 1'b1);
        chk32("redir_pc", redir_pc, v.e_pc);
        chk1("redir_flush", flush, k == 0);
        chk1("redir_req_ready", req_ready, 1'b0);
        redir_ready = (k == v.delay);
      end
    end
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_redir_valid", redir_valid, 1'b0);
    chk1("rst_resolved_valid", resolved_valid, 1'b0);
    chk32("rst_redir_pc", redir_pc, 32'h0);
    chk32("rst_cnt", 32'(mispredict_cnt), 32'h0);
    chk32("rst_cmp_operand1", cmp_operand1, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    //                pc            imm           rs1           rs2     kind pred dly  tk rd ms  e_pc          cnt
    tbl.push_back('{32'h0000_0100, 32'h20,       32'd5,        32'd5,  3'd1, 1, 0,  1, 0, 0, 32'h0,        8'd0});
    tbl.push_back('{32'h0000_0200, 32'h40,       32'd3,        32'd3,  3'd2, 1, 0,  0, 1, 0, 32'h204,      8'd1});
    tbl.push_back('{32'h0000_0300, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 3'd4, 0, 3,  1, 1, 0, 32'h2F0,      8'd2});
    tbl.push_back('{32'hFFFF_FFFC, 32'h8,        32'd1,        32'd2,  3'd1, 1, 1,  0, 1, 0, 32'h0,        8'd3});
    tbl.push_back('{32'h0000_0100, 32'h2,        32'd7,        32'd7,  3'd3, 0, 0,  1, 0, 1, 32'h0,        8'd3});
    tbl.push_back('{32'h0000_0400, 32'h10,       32'd1,        32'd2,  3'd7, 1, 0,  0, 1, 0, 32'h404,      8'd4});
    tbl.push_back('{32'h0000_0404, 32'h10,       32'd9,        32'd9,  3'd0, 0, 0,  0, 0, 0, 32'h0,        8'd4});
    tbl.push_back('{32'h0000_0500, 32'h8,        32'h8000_0000, 32'd1, 3'd3, 0, 0,  0, 0, 0, 32'h0,        8'd4});
    tbl.push_back('{32'hFFFF_FFF0, 32'h20,       32'd1,        32'd2,  3'd2, 0, 2,  1, 1, 0, 32'h10,       8'd5});
    tbl.push_back('{32'h0000_0600, 32'h6,        32'd1,        32'd2,  3'd1, 0, 0,  0, 0, 0, 32'h0,        8'd5});
    tbl.push_back('{32'h0000_0800, 32'h4,        32'd5,        32'd9,  3'd4, 1, 0,  1, 0, 0, 32'h0,        8'd5});
    foreach (tbl[i]) run(tbl[i]);
    model_cnt = 5;

    // Randomized traffic against the reference model
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a, b, imm;
      a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      b = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
      imm = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) imm = imm | 32'($urandom_range(1, 3));
      v = model($urandom & 32'hFFFF_FFFC, imm, a, b, 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      run(v);
    end

    // Reset in the middle of a held redirect
    @(negedge clk);
    chk1("mid_req_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_pc = 32'h700; req_imm = 32'h40; req_rs1 = 32'd3;
    req_rs2 = 32'd3; req_kind = 3'd2; req_pred_taken = 1'b1; redir_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk1("mid_redir_valid_first", redir_valid, 1'b1);
    chk32("mid_redir_pc", redir_pc, 32'h704);
    @(negedge clk);
    chk1("mid_redir_valid_held", redir_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("arst_redir_valid", redir_valid, 1'b0);
    chk1("arst_req_ready", req_ready, 1'b1);
    chk1("arst_flush", flush, 1'b0);
    chk32("arst_redir_pc", redir_pc, 32'h0);
    chk32("arst_cnt", 32'(mispredict_cnt), 32'h0);
    chk32("arst_cmp_operand1", cmp_operand1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    redir_ready = 1'b1;
    @(negedge clk);
    chk1("post_rst_req_ready", req_ready, 1'b1);
    chk1("post_rst_redir_valid", redir_valid, 1'b0);
    model_cnt = 0;

    // Saturation of the mispredict counter
    for (int i = 0; i < (1 << CW) + 4; i++) begin
      v = model(32'h1000 + 32'(i * 8), 32'h40, 32'd3, 32'd3, 3'd2, 1'b1, 0);
      run(v);
    end
    @(negedge clk);
    chk32("sat_cnt", 32'(mispredict_cnt), 32'(CW'('1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
